// File: rtl/fxp_pkg.sv
// Shared Q(whole.fraction) fixed-point definitions for the divider and multiplier.
package fxp_pkg;

    localparam int FXP_WHOLE = 16;
    localparam int FXP_FRAC  = 16;
    localparam int FXP_W     = FXP_WHOLE + FXP_FRAC;
    localparam int FXP_N     = FXP_W + FXP_FRAC;

    typedef logic signed [FXP_W-1:0] fxp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FINISH = 2'd2
    } div_state_t;

    localparam fxp_t FXP_MAX = {1'b0, {(FXP_W-1){1'b1}}};
    localparam fxp_t FXP_MIN = {1'b1, {(FXP_W-1){1'b0}}};

endpackage

// File: rtl/fxp_div_step.sv
// One restoring long-division step: shift the next numerator bit into the
// remainder and subtract the divisor when it fits.
module fxp_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic         num_msb_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         q_bit_o
);

    // rem_i < divisor_i <= 2^(W-1), so the shifted trial value fits in W+1 bits.
    logic [W:0] trial;
    logic [W:0] diff;

    always_comb begin
        trial   = {rem_i, num_msb_i};
        diff    = trial - {1'b0, divisor_i};
        q_bit_o = (trial >= {1'b0, divisor_i});
        rem_o   = q_bit_o ? diff[W-1:0] : trial[W-1:0];
    end

endmodule

// File: rtl/fxp_div.sv
// Iterative signed fixed-point divider, one quotient bit per clock, with
// saturation on overflow and divide-by-zero.
module fxp_div
    import fxp_pkg::*;
#(
    parameter int wholeWidth    = FXP_WHOLE,
    parameter int fractionWidth = FXP_FRAC
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic                                   start,
    input  logic [wholeWidth+fractionWidth-1:0]    dividend,
    input  logic [wholeWidth+fractionWidth-1:0]    divisor,
    output logic                                   busy,
    output logic                                   done,
    output logic [wholeWidth+fractionWidth-1:0]    quotient,
    output logic                                   overflow,
    output logic                                   div_by_zero
);

    localparam int W  = wholeWidth + fractionWidth;
    localparam int F  = fractionWidth;
    localparam int N  = W + F;
    localparam int CW = $clog2(N + 1);

    localparam logic [W-1:0] Q_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] Q_MIN = {1'b1, {(W-1){1'b0}}};

    div_state_t state_q, state_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W-1:0]  quot_q, quot_d;
    logic          ovf_q, ovf_d;
    logic          dbz_q, dbz_d;

    logic          sign_q;
    logic          dvd_neg_q;
    logic          zero_dsr_q;
    logic [W-1:0]  dsr_q;
    logic [N-1:0]  num_q;
    logic [W-1:0]  rem_q;
    logic [CW-1:0] cnt_q;

    logic [W-1:0]  rem_nxt;
    logic          q_bit;
    logic          accept;
    logic          dsr_zero;
    logic [W-1:0]  dvd_mag;
    logic [W-1:0]  dsr_mag;
    logic          pos_ovf;
    logic          neg_ovf;
    logic [W-1:0]  q_low;

    // Magnitude of -2^(W-1) is 2^(W-1), which still fits as W-bit unsigned.
    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? (~x + 1'b1) : x;
    endfunction

    assign accept   = (state_q == IDLE) && start;
    assign dsr_zero = (divisor == '0);
    assign dvd_mag  = mag(dividend);
    assign dsr_mag  = mag(divisor);

    fxp_div_step #(.W(W)) u_step (
        .rem_i     (rem_q),
        .num_msb_i (num_q[N-1]),
        .divisor_i (dsr_q),
        .rem_o     (rem_nxt),
        .q_bit_o   (q_bit)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = dsr_zero ? FINISH : DIVIDE;
            DIVIDE:  if (cnt_q == CW'(1)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Quotient magnitude lives in num_q after N shifts; anything above the
    // representable range saturates.
    always_comb begin
        q_low   = num_q[W-1:0];
        pos_ovf = |num_q[N-1:W-1];
        neg_ovf = (|num_q[N-1:W]) | (num_q[W-1] & (|num_q[W-2:0]));

        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE:   if (start) busy_d = 1'b1;
            DIVIDE: ;
            FINISH: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                if (zero_dsr_q) begin
                    quot_d = dvd_neg_q ? Q_MIN : Q_MAX;
                    ovf_d  = 1'b0;
                    dbz_d  = 1'b1;
                end else if (!sign_q && pos_ovf) begin
                    quot_d = Q_MAX;
                    ovf_d  = 1'b1;
                    dbz_d  = 1'b0;
                end else if (sign_q && neg_ovf) begin
                    quot_d = Q_MIN;
                    ovf_d  = 1'b1;
                    dbz_d  = 1'b0;
                end else begin
                    quot_d = sign_q ? (~q_low + 1'b1) : q_low;
                    ovf_d  = 1'b0;
                    dbz_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            quot_q <= '0;
            ovf_q  <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            quot_q <= quot_d;
            ovf_q  <= ovf_d;
            dbz_q  <= dbz_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sign_q     <= 1'b0;
            dvd_neg_q  <= 1'b0;
            zero_dsr_q <= 1'b0;
            dsr_q      <= '0;
            num_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
        end else if (accept) begin
            sign_q     <= dividend[W-1] ^ divisor[W-1];
            dvd_neg_q  <= dividend[W-1];
            zero_dsr_q <= dsr_zero;
            dsr_q      <= dsr_mag;
            num_q      <= {dvd_mag, {F{1'b0}}};
            rem_q      <= '0;
            cnt_q      <= CW'(N);
        end else if (state_q == DIVIDE) begin
            num_q      <= {num_q[N-2:0], q_bit};
            rem_q      <= rem_nxt;
            cnt_q      <= cnt_q - CW'(1);
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fxp_div.sv
// Self-checking bench for fxp_div at 16.16: vector table, random operands
// against a 64-bit reference, busy-start and mid-divide reset sequences.
module tb_fxp_div;

    localparam int W = 32;
    localparam int F = 16;
    localparam int N = W + F;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          busy;
    logic          done;
    logic [W-1:0]  quotient;
    logic          overflow;
    logic          div_by_zero;

    fxp_div #(.wholeWidth(16), .fractionWidth(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        bit           ovf;
        bit           dbz;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        bit           ovf;
        bit           dbz;
        int           lat;
        int           acc;
    } sb_t;

    sb_t sb[$];
    int  cyc    = 0;
    int  passed = 0;
    int  total  = 0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Independent reference: 64-bit signed division truncates toward zero.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output bit ovf, output bit dbz);
        longint sa, sbv, r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ovf = 0;
        dbz = 0;
        if (sbv == 0) begin
            dbz = 1;
            q   = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            r = (sa * 65536) / sbv;
            if (r > 64'sd2147483647) begin
                q = 32'h7FFF_FFFF; ovf = 1;
            end else if (r < -64'sd2147483648) begin
                q = 32'h8000_0000; ovf = 1;
            end else begin
                q = r[W-1:0];
            end
        end
    endtask

    // Monitor: pops the scoreboard on every done and checks pulse width.
    logic         prev_done = 1'b0;
    logic [W-1:0] held_q;
    always @(negedge clock) begin
        if (prev_done) begin
            check("done_one_cycle", {31'd0, done}, 32'd0);
            check("quotient_held", quotient, held_q);
        end
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                check("latency", cyc - e.acc, e.lat);
            end
        end
        prev_done = done;
        held_q    = quotient;
    end

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            total++;
            $display("FAIL timeout: %0d results outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input bit eo, input bit ed);
        sb_t e;
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.q   = eq;
        e.ovf = eo;
        e.dbz = ed;
        e.lat = (b == '0) ? 1 : N + 1;
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0;
        wait_drain();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_quotient"}, quotient, 32'd0);
        check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        check({tag, "_div_by_zero"}, {31'd0, div_by_zero}, 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        logic [W-1:0] ra, rb, rq;
        bit           ro, rd;
        sb_t          e;

        vecs[0]  = '{32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 0, 0};
        vecs[1]  = '{32'hFFFE_8000, 32'h0000_8000, 32'hFFFD_0000, 0, 0};
        vecs[2]  = '{32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 0, 0};
        vecs[3]  = '{32'h4000_0000, 32'h0000_0100, 32'h7FFF_FFFF, 1, 0};
        vecs[4]  = '{32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1, 0};
        vecs[5]  = '{32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 0, 1};
        vecs[6]  = '{32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 0, 1};
        vecs[7]  = '{32'h0000_0000, 32'h0003_0000, 32'h0000_0000, 0, 0};
        vecs[8]  = '{32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 0, 0};
        vecs[9]  = '{32'h7FFF_FFFF, 32'h0001_0000, 32'h7FFF_FFFF, 0, 0};
        vecs[10] = '{32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 0, 0};
        vecs[11] = '{32'h4000_0000, 32'hFFFF_FF00, 32'h8000_0000, 1, 0};

        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        reset_n = 1'b1;

        foreach (vecs[i]) run(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].ovf, vecs[i].dbz);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if ($urandom_range(0, 1) == 1) rb = ~rb + 1'b1;
            model(ra, rb, rq, ro, rd);
            run(ra, rb, rq, ro, rd);
        end

        // start pulsed with other operands five edges into a divide is ignored
        model(32'h0007_0000, 32'h0002_0000, rq, ro, rd);
        @(negedge clock);
        dividend = 32'h0007_0000;
        divisor  = 32'h0002_0000;
        start    = 1'b1;
        e = '{q: rq, ovf: ro, dbz: rd, lat: N + 1, acc: cyc + 1};
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        dividend = 32'h0100_0000;
        divisor  = 32'h0000_0000;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h1234_5678;
        check("busy_during_divide", {31'd0, busy}, 32'd1);
        wait_drain();
        repeat (5) @(negedge clock);

        // leave non-zero outputs behind, then reset ten edges into a divide
        run(32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 0, 1);
        @(negedge clock);
        dividend = 32'h0003_0000;
        divisor  = 32'h0002_0000;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        @(posedge clock);
        #1;
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (N + 5) @(negedge clock);
        run(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 0, 0);
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
